inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped instruction cache; the requesting end of the 128-bit line-fetch interface of the instruction memory.
//  CPU fetch stage presents a 32-bit PC; on hit the block returns the 32-bit instruction combinationally.
//  On miss it stalls the CPU, drives the line address to instruction memory and holds it stable for the memory
//  delay, then captures the 128-bit dataline and fills the line.
// PARAMETERS
//  IDX_BITS   3  log2 of line count (8 lines x 16 bytes)
//  MEM_WAIT   7  clock edges from mem_address update to dataline capture (memory: 1 mismatch + 4 count + 1 load edge, +1 margin)
// PORTS
//  clk           in   1    clock, all state on posedge
//  reset         in   1    asynchronous, active-high
//  pc            in   32   fetch address; pc[1:0] ignored
//  req           in   1    fetch request this cycle
//  instruction   out  32   word at pc; valid when ready=1, else 32'b0
//  ready         out  1    req & hit & state==IDLE (combinational)
//  stall         out  1    req & ~ready, or state==FILL
//  mem_address   out  32   registered line address {line_tag_idx, 4'b0}
//  mem_dataline  in   128  line from instruction memory; byte k at [8k+7:8k]
// BEHAVIOUR
//  - Address split: offset pc[3:0], word pc[3:2], index pc[4+IDX_BITS-1:4], tag pc[31:4+IDX_BITS].
//  - Word select: instruction = line[32*pc[3:2] +: 32] (little-endian bytes, byte 0 at LSB).
//  - Reset values: all valid bits 0, state IDLE, mem_address 32'b0, wait_cnt 0; ready/instruction/stall follow (0/0/req).
//  - FSM IDLE: req & hit -> stay, ready=1. req & miss -> FILL; same edge: mem_address <= {pc[31:4],4'b0},
//    fill_idx/fill_tag latched, wait_cnt <= 0.
//  - FSM FILL: wait_cnt increments each edge; on edge where wait_cnt == MEM_WAIT-1: data[fill_idx] <= mem_dataline,
//    tag written, valid set, -> IDLE. Ready never asserts in FILL.
//  - Latency: miss costs MEM_WAIT+1 cycles; the repeated same-pc request hits in the first IDLE cycle after fill.
//  - mem_address changes only on FILL entry; never toggles otherwise (memory restarts its delay on any [31:4] change).
//  - pc/req changing mid-fill: ignored; fill completes for the latched address; new pc looked up in IDLE afterwards.
//  - Miss to invalid line whose line address equals current mem_address: still full MEM_WAIT wait (memory dataline is
//    stable in that case, capture is correct).
//  - Conflict miss evicts unconditionally (no dirty state; read-only).
//  - reset asserted mid-fill: fill aborted, no line written, all valid cleared, IDLE next.
//  - wait_cnt width $clog2(MEM_WAIT)+1, saturates never (FSM exits first).
// CONFIGURATION
//  INST_CACHE_STATS_EN defined: adds outputs hit_count[31:0], miss_count[31:0]; hit_count +1 per cycle with ready=1,
//   miss_count +1 per FILL entry; both reset to 0, wrap modulo 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package inst_cache_pkg: FSM state encoding (IDLE=0, FILL=1), LINE_BYTES=16, LINE_BITS=128, WORD_BITS=32,
//   OFFSET_BITS=4, default MEM_WAIT.
//  Sub-module inst_cache_line_store: data/tag/valid arrays, async read by index, sync write port, async clear
//   of valid on reset. FSM, counter, word mux in inst_cache.
// TESTING
//  1 Reset, req=1 pc=0x0000_0000 -> stall=1, mem_address=0x0, after 8 cycles ready=1, instruction=bytes 3..0 of line.
//  2 After test 1, pc=0x4,0x8,0xC back-to-back -> ready=1 each cycle, no mem_address change.
//  3 pc=0x0000_0080 (same index 0, new tag) -> miss, mem_address=0x80, refill; then pc=0x0 -> miss again (eviction).
//  4 Miss at pc=0x10, change pc to 0x20 at wait_cnt=3 -> line 1 filled for tag of 0x10, then 0x20 misses and fills.
//  5 Assert reset at wait_cnt=4 of a fill -> valid cleared, mem_address=0; next req same pc misses again.
//  6 With INST_CACHE_STATS_EN: tests 1-2 sequence -> miss_count=1, hit_count=4 (incl. the post-fill hit at pc 0x0).

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the FSM state encoding, line/word geometry, default timing and
// the word-select helper used on the hit path.
package inst_cache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam int unsigned LINE_BYTES       = 16;
    localparam int unsigned LINE_BITS        = 128;
    localparam int unsigned WORD_BITS        = 32;
    localparam int unsigned ADDR_BITS        = 32;
    localparam int unsigned OFFSET_BITS      = $clog2(LINE_BYTES);
    localparam int unsigned DEFAULT_IDX_BITS = 3;
    localparam int unsigned DEFAULT_MEM_WAIT = 7;

    // Little-endian word pick: word 0 occupies the low 32 bits of the line.
    function automatic logic [WORD_BITS-1:0] select_word(
        input logic [LINE_BITS-1:0] line,
        input logic [1:0]           word
    );
        logic [WORD_BITS-1:0] w;
        case (word)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_cache_line_store.sv
// Line storage for inst_cache: data, tag and valid arrays.
// Ports:
//   clk, reset         clock / async active-high reset (clears valid bits only)
//   i_rd_idx           lookup index
//   o_rd_data_c/_tag_c/_valid_c  combinational read of the indexed line
//   i_wr_en/_idx/_tag/_data      synchronous line fill
module inst_cache_line_store
    import inst_cache_pkg::*;
#(
    parameter int unsigned IDX_BITS = DEFAULT_IDX_BITS,
    parameter int unsigned TAG_BITS = ADDR_BITS - OFFSET_BITS - DEFAULT_IDX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_BITS-1:0]  i_rd_idx,
    output logic [LINE_BITS-1:0] o_rd_data_c,
    output logic [TAG_BITS-1:0]  o_rd_tag_c,
    output logic                 o_rd_valid_c,
    input  logic                 i_wr_en,
    input  logic [IDX_BITS-1:0]  i_wr_idx,
    input  logic [TAG_BITS-1:0]  i_wr_tag,
    input  logic [LINE_BITS-1:0] i_wr_data
);

    localparam int unsigned LINES = 1 << IDX_BITS;

    logic [LINE_BITS-1:0] r_data  [LINES];
    logic [TAG_BITS-1:0]  r_tag   [LINES];
    logic [LINES-1:0]     r_valid;

    // Data and tag need no reset: a line is only visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
            r_tag[i_wr_idx]  <= i_wr_tag;
        end
    end

    // Valid bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    assign o_rd_data_c  = r_data[i_rd_idx];
    assign o_rd_tag_c   = r_tag[i_rd_idx];
    assign o_rd_valid_c = r_valid[i_rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with a 128-bit line-fill port.
// Hits return the addressed word combinationally; a miss stalls the fetch
// stage, holds the line address on mem_address for MEM_WAIT edges, then
// captures mem_dataline into the line.
// Ports:
//   clk, reset        clock / async active-high reset
//   pc, req           fetch address (pc[1:0] ignored) and request
//   instruction       word at pc when ready, else 0
//   ready, stall      hit-in-IDLE / fetch must wait
//   mem_address       registered line address to instruction memory
//   mem_dataline      line returned by instruction memory
//   hit_count, miss_count  only when INST_CACHE_STATS_EN is defined
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned IDX_BITS = DEFAULT_IDX_BITS,
    parameter int unsigned MEM_WAIT = DEFAULT_MEM_WAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] pc,
    input  logic                 req,
    output logic [WORD_BITS-1:0] instruction,
    output logic                 ready,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] mem_address,
    input  logic [LINE_BITS-1:0] mem_dataline
`ifdef INST_CACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int unsigned TAG_BITS = ADDR_BITS - OFFSET_BITS - IDX_BITS;
    localparam int unsigned CNT_BITS = $clog2(MEM_WAIT) + 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_BITS-1:0]   r_wait_cnt;
    logic [IDX_BITS-1:0]   r_fill_idx;
    logic [TAG_BITS-1:0]   r_fill_tag;
    logic [ADDR_BITS-1:0]  r_mem_address;

    logic [IDX_BITS-1:0]   w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic [LINE_BITS-1:0]  w_rd_data;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic                  w_rd_valid;
    logic                  w_hit;
    logic                  w_ready;
    logic                  w_fill_start;
    logic                  w_fill_done;
    logic                  w_unused_pc;

    assign w_idx       = pc[OFFSET_BITS +: IDX_BITS];
    assign w_tag       = pc[ADDR_BITS-1 -: TAG_BITS];
    assign w_unused_pc = ^pc[1:0];

    inst_cache_line_store #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_line_store (
        .clk          (clk),
        .reset        (reset),
        .i_rd_idx     (w_idx),
        .o_rd_data_c  (w_rd_data),
        .o_rd_tag_c   (w_rd_tag),
        .o_rd_valid_c (w_rd_valid),
        .i_wr_en      (w_fill_done),
        .i_wr_idx     (r_fill_idx),
        .i_wr_tag     (r_fill_tag),
        .i_wr_data    (mem_dataline)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, fill handshake and hit qualification
    always_comb begin
        w_next_state = r_state;
        w_fill_start = 1'b0;
        w_fill_done  = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_hit) begin
                        w_ready = 1'b1;
                    end else begin
                        w_fill_start = 1'b1;
                        w_next_state = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (r_wait_cnt == CNT_BITS'(MEM_WAIT - 1)) begin
                    w_fill_done  = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Fill address/counter; mem_address moves only on fill entry so the
    // memory never restarts its delay mid-fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_address <= '0;
            r_wait_cnt    <= '0;
            r_fill_idx    <= '0;
            r_fill_tag    <= '0;
        end else if (w_fill_start) begin
            r_mem_address <= {pc[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
            r_fill_idx    <= w_idx;
            r_fill_tag    <= w_tag;
            r_wait_cnt    <= '0;
        end else if (r_state == ST_FILL) begin
            r_wait_cnt <= r_wait_cnt + CNT_BITS'(1);
        end
    end

    assign ready       = w_ready;
    assign stall       = (req && !w_ready) || (r_state == ST_FILL);
    assign instruction = w_ready ? select_word(w_rd_data, pc[3:2]) : '0;
    assign mem_address = r_mem_address;

`ifdef INST_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit/miss statistics, wrapping modulo 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_ready) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fill_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_inst_cache.sv
`timescale 1ns/1ps
module tb_inst_cache;

    localparam int MEM_WAIT = 7;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  pc    = 32'h0;
    logic         req   = 1'b0;
    logic [31:0]  instruction;
    logic         ready;
    logic         stall;
    logic [31:0]  mem_address;
    logic [127:0] mem_dataline;
`ifdef INST_CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    inst_cache dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .req          (req),
        .instruction  (instruction),
        .ready        (ready),
        .stall        (stall),
        .mem_address  (mem_address),
        .mem_dataline (mem_dataline)
`ifdef INST_CACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    // Instruction content: each word is derived from its own byte address.
    function automatic logic [31:0] word_val(input logic [31:0] b);
        return {b[15:0] ^ 16'hA5C3, b[15:0]};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[32*w +: 32] = word_val({a[31:4], 4'h0} + 32'(4 * w));
        end
        return l;
    endfunction

    // Instruction memory: data becomes valid 6 edges after the address changes.
    logic [31:0] mem_seen = 32'h0;
    int          mem_age  = 100;
    always @(posedge clk) begin
        if (mem_address[31:4] != mem_seen[31:4]) begin
            mem_seen <= mem_address;
            mem_age  <= 0;
        end else if (mem_age < 100) begin
            mem_age <= mem_age + 1;
        end
    end
    assign mem_dataline = (mem_age >= 5) ? line_of(mem_seen) : {4{32'hBAD0_BAD0}};

    // Reference model: cache contents as a table of resident line addresses.
    logic        m_valid [8];
    logic [27:0] m_laddr [8];
    logic        m_busy;
    int          m_left;
    logic [27:0] m_fill;
    logic [31:0] m_mem_addr;
    int          m_hits;
    int          m_misses;

    function automatic logic m_hit(input logic [31:0] a);
        return m_valid[a[6:4]] && (m_laddr[a[6:4]] == a[31:4]);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_valid[i] <= 1'b0;
            m_busy     <= 1'b0;
            m_left     <= 0;
            m_mem_addr <= 32'h0;
            m_hits     <= 0;
            m_misses   <= 0;
        end else if (!m_busy) begin
            if (req && !m_hit(pc)) begin
                m_busy     <= 1'b1;
                m_left     <= MEM_WAIT;
                m_fill     <= pc[31:4];
                m_mem_addr <= {pc[31:4], 4'h0};
                m_misses   <= m_misses + 1;
            end else if (req) begin
                m_hits <= m_hits + 1;
            end
        end else begin
            if (m_left == 1) begin
                m_busy               <= 1'b0;
                m_valid[m_fill[2:0]] <= 1'b1;
                m_laddr[m_fill[2:0]] <= m_fill;
            end
            m_left <= m_left - 1;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic e_ready;
            e_ready = !m_busy && req && m_hit(pc);
            check32("ready", {31'b0, ready}, {31'b0, e_ready});
            check32("stall", {31'b0, stall}, {31'b0, m_busy || (req && !e_ready)});
            check32("instruction", instruction, e_ready ? word_val({pc[31:2], 2'b00}) : 32'h0);
            check32("mem_address", mem_address, m_mem_addr);
`ifdef INST_CACHE_STATS_EN
            check32("hit_count", hit_count, 32'(m_hits));
            check32("miss_count", miss_count, 32'(m_misses));
`endif
        end
    end

    task automatic drive(input logic [31:0] a, input logic r);
        @(posedge clk);
        #1;
        pc  = a;
        req = r;
    endtask

    // Counts stalled cycles before the first ready, bounded.
    task automatic wait_ready(input string name, input int expect_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check32({name, "_latency"}, 32'(n), 32'(expect_cycles));
    endtask

    initial begin
        #1 reset = 1'b1;
        chk_en = 1'b1;

        // Test 1: cold miss at pc 0 straight out of reset
        drive(32'h0, 1'b1);
        @(negedge clk);
        check32("t1_reset_stall", {31'b0, stall}, 32'd1);
        check32("t1_reset_ready", {31'b0, ready}, 32'd0);
        check32("t1_reset_mem", mem_address, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready("t1", 8);
        check32("t1_instr", instruction, 32'hA5C3_0000);
        check32("t1_mem", mem_address, 32'h0);

        // Test 2: remaining words of line 0 hit back-to-back
        drive(32'h4, 1'b1);
        @(negedge clk);
        check32("t2_instr4", instruction, 32'hA5C7_0004);
        drive(32'h8, 1'b1);
        @(negedge clk);
        check32("t2_instr8", instruction, 32'hA5CB_0008);
        drive(32'hC, 1'b1);
        @(negedge clk);
        check32("t2_instrC", instruction, 32'hA5CF_000C);
        check32("t2_readyC", {31'b0, ready}, 32'd1);
        check32("t2_mem", mem_address, 32'h0);
        drive(32'hC, 1'b0);
        @(negedge clk);
        check32("t2_idle_stall", {31'b0, stall}, 32'd0);
        check32("t2_idle_instr", instruction, 32'h0);
`ifdef INST_CACHE_STATS_EN
        check32("t6_hits", hit_count, 32'd4);
        check32("t6_misses", miss_count, 32'd1);
`endif

        // Test 3: conflict miss on index 0, then eviction of the original line
        drive(32'h80, 1'b1);
        wait_ready("t3", 8);
        check32("t3_mem", mem_address, 32'h80);
        check32("t3_instr", instruction, 32'hA543_0080);
        drive(32'h0, 1'b1);
        wait_ready("t3_evict", 8);
        check32("t3_evict_instr", instruction, 32'hA5C3_0000);

        // Test 4: pc changes mid-fill; latched fill completes, new pc then misses
        drive(32'h10, 1'b1);
        repeat (4) @(posedge clk);
        #1 pc = 32'h20;
        wait_ready("t4", 12);
        check32("t4_instr", instruction, 32'hA5E3_0020);
        check32("t4_mem", mem_address, 32'h20);
        drive(32'h10, 1'b1);
        @(negedge clk);
        check32("t4_line1_ready", {31'b0, ready}, 32'd1);
        check32("t4_line1_instr", instruction, 32'hA5D3_0010);

        // Test 5: reset mid-fill aborts the fill and clears all lines
        drive(32'h30, 1'b1);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check32("t5_reset_mem", mem_address, 32'h0);
        check32("t5_reset_ready", {31'b0, ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready("t5", 8);
        check32("t5_instr", instruction, 32'hA5F3_0030);
        drive(32'h10, 1'b1);
        @(negedge clk);
        check32("t5_line1_gone", {31'b0, ready}, 32'd0);
        wait_ready("t5_refill", 7);

        drive(32'h0, 1'b0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
